// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit instruction
// words and writes them to consecutive instruction-memory addresses from 0,
// stalling the CPU until a halt-opcode word or the last address is written.
module imem_loader #(
   parameter int          DEPTH       = 128,
   parameter int          ADDR_W      = 7,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byteIn,
   input  logic              byteValid,
   output logic              byteReady,
   output logic              wrEn,
   output logic [ADDR_W-1:0] wrAdrx,
   output logic [31:0]       wrData,
   output logic              cpuHold,
   output logic              done,
   output logic [ADDR_W:0]   wordCount
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;        // address of the word being assembled
   logic [1:0]          idx_q, idx_d;          // bytes already taken for this word
   logic [23:0]         word_q, word_d;        // first three bytes, MSB first
   logic [ADDR_W-1:0]   wrAdrx_q, wrAdrx_d;
   logic [31:0]         wrData_q, wrData_d;
   logic [ADDR_W:0]     wordCount_q, wordCount_d;

   // Outputs that depend only on the phase come straight from the state register.
   assign byteReady = (state_q == S_LOAD);
   assign wrEn      = (state_q == S_WRITE);
   assign cpuHold   = (state_q == S_LOAD) || (state_q == S_WRITE);
   assign done      = (state_q == S_DONE);
   assign wrAdrx    = wrAdrx_q;
   assign wrData    = wrData_q;
   assign wordCount = wordCount_q;

   // Next-state logic: byte capture, word hand-off to the write phase, end detection.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      idx_d       = idx_q;
      word_d      = word_q;
      wrAdrx_d    = wrAdrx_q;
      wrData_d    = wrData_q;
      wordCount_d = wordCount_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_LOAD;
               addr_d      = '0;
               idx_d       = 2'd0;
               wordCount_d = '0;
            end
         end
         S_LOAD: begin
            if (byteValid) begin
               word_d = {word_q[15:0], byteIn};
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  // Write port registers are loaded here so they are valid in the WRITE cycle.
                  wrData_d = {word_q, byteIn};
                  wrAdrx_d = addr_q;
                  idx_d    = 2'd0;
                  state_d  = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            wordCount_d = wordCount_q + {{ADDR_W{1'b0}}, 1'b1};
            // The halt word is written too; the last address stops the load without wrapping.
            if ((wrData_q[31:26] == HALT_OPCODE) || (addr_q == ADDR_W'(DEPTH - 1))) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset; a partial word is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         idx_q       <= 2'd0;
         word_q      <= '0;
         wrAdrx_q    <= '0;
         wrData_q    <= '0;
         wordCount_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         wrAdrx_q    <= wrAdrx_d;
         wrData_q    <= wrData_d;
         wordCount_q <= wordCount_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle vector table, directed corner
// sequences and randomized programs checked against a write-list model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset, start, byteValid;
   logic [7:0]  byteIn;
   logic        byteReady, wrEn, cpuHold, done;
   logic [6:0]  wrAdrx;
   logic [31:0] wrData;
   logic [7:0]  wordCount;

   int nchk = 0;
   int nerr = 0;

   logic [38:0] wlog[$];   // {address, data} of every observed write strobe

   imem_loader dut (
      .clk(clk), .reset(reset), .start(start), .byteIn(byteIn),
      .byteValid(byteValid), .byteReady(byteReady), .wrEn(wrEn),
      .wrAdrx(wrAdrx), .wrData(wrData), .cpuHold(cpuHold), .done(done),
      .wordCount(wordCount)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wrEn) wlog.push_back({wrAdrx, wrData});

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        st, vld;
      logic [7:0]  b;
      logic        rdy, we;
      logic [6:0]  adr;
      logic [31:0] dat;
      logic        hold, dn;
      logic [7:0]  wc;
   } vec_t;

   function automatic logic [63:0] pack_out(input logic rdy, we, input logic [6:0] adr,
                                            input logic [31:0] dat, input logic hold, dn,
                                            input logic [7:0] wc);
      return {11'd0, rdy, we, adr, dat, hold, dn, wc};
   endfunction

   // Present one byte (with optional random idle cycles first); returns after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int bub_pct);
      int n;
      n = 0;
      while (($urandom_range(99) < bub_pct) && n < 4) begin
         byteValid = 1'b0; tick(); n++;
      end
      byteValid = 1'b1; byteIn = b;
      n = 0;
      while (!byteReady && n < 20) begin tick(); n++; end
      if (n == 20) chk("byte_accept_timeout", 64'(byteReady), 64'd1);
      else tick();
      byteValid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int bub_pct);
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], bub_pct);
      chk("wren_after_4th", 64'(wrEn), 64'd1);
   endtask

   // Model: words land at 0,1,2,... and the load ends on a halt opcode or address 127.
   task automatic run_prog(input string name, input logic [31:0] words[$], input int bub_pct);
      logic [38:0] exp[$];
      for (int i = 0; i < words.size(); i++) begin
         exp.push_back({7'(i), words[i]});
         if (words[i][31:26] == 6'h3f || i == 127) break;
      end
      wlog.delete();
      start = 1'b1; tick(); start = 1'b0;
      chk({name, "_hold_on_start"}, 64'(cpuHold), 64'd1);
      chk({name, "_wc_cleared"}, 64'(wordCount), 64'd0);
      for (int i = 0; i < exp.size(); i++) send_word(exp[i][31:0], bub_pct);
      tick();
      chk({name, "_done"}, 64'({done, cpuHold, byteReady}), 64'b100);
      chk({name, "_wordcount"}, 64'(wordCount), 64'(exp.size()));
      chk({name, "_nwrites"}, 64'(wlog.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < wlog.size(); i++)
         chk({name, "_write"}, 64'(wlog[i]), 64'(exp[i]));
   endtask

   initial begin
      vec_t        vecs[11];
      logic [31:0] prog[$];
      logic [7:0]  bub_b[7];
      logic        bub_v[7];
      logic [31:0] w;

      reset = 1'b1; start = 1'b0; byteValid = 1'b0; byteIn = 8'h00;
      tick(); tick();
      chk("reset_values", pack_out(byteReady, wrEn, wrAdrx, wrData, cpuHold, done, wordCount),
          64'd0);
      reset = 1'b0;

      //          st  vld  b       rdy we adr  dat            hold dn wc
      vecs[0]  = '{0, 1, 8'hAA,   0, 0, 7'd0, 32'h0,         0, 0, 8'd0};
      vecs[1]  = '{1, 0, 8'h00,   1, 0, 7'd0, 32'h0,         1, 0, 8'd0};
      vecs[2]  = '{0, 1, 8'hFC,   1, 0, 7'd0, 32'h0,         1, 0, 8'd0};
      vecs[3]  = '{0, 1, 8'h00,   1, 0, 7'd0, 32'h0,         1, 0, 8'd0};
      vecs[4]  = '{0, 0, 8'h00,   1, 0, 7'd0, 32'h0,         1, 0, 8'd0};
      vecs[5]  = '{0, 1, 8'h00,   1, 0, 7'd0, 32'h0,         1, 0, 8'd0};
      vecs[6]  = '{0, 1, 8'h00,   0, 1, 7'd0, 32'hFC000000,  1, 0, 8'd0};
      vecs[7]  = '{0, 1, 8'h55,   0, 0, 7'd0, 32'hFC000000,  0, 1, 8'd1};
      vecs[8]  = '{0, 1, 8'h55,   0, 0, 7'd0, 32'hFC000000,  0, 1, 8'd1};
      vecs[9]  = '{1, 0, 8'h00,   1, 0, 7'd0, 32'hFC000000,  1, 0, 8'd0};
      vecs[10] = '{0, 1, 8'h8C,   1, 0, 7'd0, 32'hFC000000,  1, 0, 8'd0};
      wlog.delete();
      foreach (vecs[i]) begin
         start = vecs[i].st; byteValid = vecs[i].vld; byteIn = vecs[i].b;
         tick();
         chk($sformatf("vec%0d", i),
             pack_out(byteReady, wrEn, wrAdrx, wrData, cpuHold, done, wordCount),
             pack_out(vecs[i].rdy, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].hold,
                      vecs[i].dn, vecs[i].wc));
      end
      start = 1'b0;
      chk("vec_nwrites", 64'(wlog.size()), 64'd1);

      // Reset after two bytes of a word: nothing is written, outputs return to reset values.
      send_byte(8'h09, 0);
      wlog.delete();
      reset = 1'b1; tick();
      chk("midword_reset_values",
          pack_out(byteReady, wrEn, wrAdrx, wrData, cpuHold, done, wordCount), 64'd0);
      reset = 1'b0;
      byteValid = 1'b1; byteIn = 8'h00; tick(); tick(); byteValid = 1'b0; tick();
      chk("midword_reset_nowrite", 64'(wlog.size()), 64'd0);
      prog = '{32'hFC000000};
      run_prog("after_reset", prog, 0);

      // Short program ending in a halt word.
      prog = '{32'h8C090000, 32'h8C0A0001, 32'h01495022, 32'hFC000000};
      run_prog("short", prog, 0);

      // Bubble pattern 1,0,0,1,0,1,1 carrying 8C 09 00 00.
      bub_v = '{1, 0, 0, 1, 0, 1, 1};
      bub_b = '{8'h8C, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
      wlog.delete();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         byteValid = bub_v[i]; byteIn = bub_b[i]; tick();
         if (i < 6) chk("bubble_no_early_write", 64'(wrEn), 64'd0);
      end
      byteValid = 1'b0;
      chk("bubble_write", {31'd0, wrEn, wrData}, {31'd0, 1'b1, 32'h8C090000});
      tick();
      chk("bubble_nwrites", 64'(wlog.size()), 64'd1);

      // Start during LOAD is ignored.
      wlog.delete();
      reset = 1'b1; tick(); reset = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      send_word(32'h11111111, 0);
      send_byte(8'h22, 0); send_byte(8'h22, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("start_in_load_state", 64'({byteReady, cpuHold, done}), 64'b110);
      chk("start_in_load_wc", 64'(wordCount), 64'd1);
      send_byte(8'h22, 0); send_byte(8'h22, 0);
      chk("start_in_load_adr", 64'({wrEn, wrAdrx}), 64'({1'b1, 7'd1}));
      send_word(32'hFC000000, 0);
      tick();
      chk("start_in_load_done", 64'({done, wordCount}), 64'({1'b1, 8'd3}));

      // Full memory without a halt word, then bytes presented after the end.
      prog.delete();
      for (int i = 0; i < 128; i++) prog.push_back(32'h0);
      run_prog("full", prog, 0);
      byteValid = 1'b1; byteIn = 8'hFC;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("full_no_ready", 64'({byteReady, wrEn, done}), 64'b001);
      end
      byteValid = 1'b0;
      chk("full_nwrites_after", 64'(wlog.size()), 64'd128);

      // Randomized programs with random bubbles, each started from DONE.
      for (int r = 0; r < 8; r++) begin
         prog.delete();
         for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
            w = $urandom();
            if (w[31:26] == 6'h3f) w[26] = 1'b0;
            if ($urandom_range(99) < 12) w[31:26] = 6'h3f;
            prog.push_back(w);
         end
         prog.push_back({6'h3f, 26'($urandom())});
         run_prog($sformatf("rand%0d", r), prog, int'($urandom_range(0, 40)));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
